// File: rtl/nfa_engine_prog.sv
// Runtime-programmable homogeneous NFA built from an array of state transition
// elements (STEs). Match classes, predecessor edges and start types live in
// writable tables, so one instance can host any automaton of up to NUM_STES
// states. One symbol is consumed per cycle with run=1, and the resulting active
// vector is reported together with the stream offset of that symbol.
module nfa_engine_prog #(
  parameter int                  NUM_STES    = 16,
  parameter int                  SYMBOL_W    = 8,
  parameter int                  OFFSET_W    = 16,
  parameter logic [NUM_STES-1:0] REPORT_MASK = {NUM_STES{1'b1}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                stream_start,
  input  logic [SYMBOL_W-1:0] symbols,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_sel,
  input  logic [SYMBOL_W-1:0] cfg_addr,
  input  logic [NUM_STES-1:0] cfg_data,
  output logic                cfg_err,
  output logic [NUM_STES-1:0] active_state,
  output logic [NUM_STES-1:0] report_vec,
  output logic                report_any,
  output logic [OFFSET_W-1:0] report_offset
);

  localparam int NUM_SYMS = 2 ** SYMBOL_W;
  localparam int IDX_W    = (NUM_STES > 1) ? $clog2(NUM_STES) : 1;

  // STE count widened by one bit so the address range check never truncates.
  localparam logic [SYMBOL_W:0] STE_LIMIT = (SYMBOL_W + 1)'(NUM_STES);

  localparam logic [1:0] SEL_MATCH = 2'd0;
  localparam logic [1:0] SEL_PRED  = 2'd1;
  localparam logic [1:0] SEL_SOD   = 2'd2;
  localparam logic [1:0] SEL_ALL   = 2'd3;

  // Configuration tables: match_q[s][i] = STE i accepts symbol s,
  // pred_q[i][j] = edge from STE j into STE i.
  logic [NUM_STES-1:0] match_q [NUM_SYMS];
  logic [NUM_STES-1:0] match_d [NUM_SYMS];
  logic [NUM_STES-1:0] pred_q  [NUM_STES];
  logic [NUM_STES-1:0] pred_d  [NUM_STES];
  logic [NUM_STES-1:0] start_sod_q, start_sod_d;
  logic [NUM_STES-1:0] start_all_q, start_all_d;

  logic [NUM_STES-1:0] active_q, active_d;
  logic [OFFSET_W-1:0] ctr_q, ctr_d;
  logic                sod_pending_q, sod_pending_d;
  logic                cfg_err_q, cfg_err_d;

  logic                addr_bad;
  logic                cfg_ok;
  logic [IDX_W-1:0]    pred_idx;
  logic                sod;
  logic [NUM_STES-1:0] prev;
  logic [NUM_STES-1:0] enable;
  logic [NUM_STES-1:0] step_state;
  logic [OFFSET_W-1:0] ctr_next;

  // Decode config writes: writes are only safe while the engine is idle, and
  // predecessor rows must address an existing STE.
  always_comb begin
    addr_bad  = (cfg_sel == SEL_PRED) && ({1'b0, cfg_addr} >= STE_LIMIT);
    cfg_ok    = cfg_we && !run && !addr_bad;
    cfg_err_d = cfg_we && (run || addr_bad);
    pred_idx  = cfg_addr[IDX_W-1:0];
  end

  // Next contents of the configuration tables.
  always_comb begin
    match_d     = match_q;
    pred_d      = pred_q;
    start_sod_d = start_sod_q;
    start_all_d = start_all_q;
    if (cfg_ok) begin
      case (cfg_sel)
        SEL_MATCH: match_d[cfg_addr] = cfg_data;
        SEL_PRED:  pred_d[pred_idx]  = cfg_data;
        SEL_SOD:   start_sod_d       = cfg_data;
        SEL_ALL:   start_all_d       = cfg_data;
        default:   ;
      endcase
    end
  end

  // One NFA step: a new stream drops all history before edges are followed,
  // so matches from the previous stream never leak into the new one.
  always_comb begin
    sod    = sod_pending_q || stream_start;
    prev   = sod ? '0 : active_q;
    enable = '0;
    for (int i = 0; i < NUM_STES; i++) begin
      enable[i] = start_all_q[i] | (sod & start_sod_q[i]) | (|(prev & pred_q[i]));
    end
    step_state = match_q[symbols] & enable;
    ctr_next   = sod ? '0 : ctr_q + 1'b1;
  end

  // Commit the step only on run cycles; otherwise everything holds.
  always_comb begin
    active_d      = active_q;
    ctr_d         = ctr_q;
    sod_pending_d = sod_pending_q;
    if (run) begin
      active_d      = step_state;
      ctr_d         = ctr_next;
      sod_pending_d = 1'b0;
    end
  end

  // Engine state registers; reset leaves the engine waiting for a new stream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_q      <= '0;
      ctr_q         <= '0;
      sod_pending_q <= 1'b1;
      cfg_err_q     <= 1'b0;
    end else begin
      active_q      <= active_d;
      ctr_q         <= ctr_d;
      sod_pending_q <= sod_pending_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  // Configuration table registers; reset wipes the loaded automaton.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SYMS; s++) match_q[s] <= '0;
      for (int i = 0; i < NUM_STES; i++) pred_q[i]  <= '0;
      start_sod_q <= '0;
      start_all_q <= '0;
    end else begin
      for (int s = 0; s < NUM_SYMS; s++) match_q[s] <= match_d[s];
      for (int i = 0; i < NUM_STES; i++) pred_q[i]  <= pred_d[i];
      start_sod_q <= start_sod_d;
      start_all_q <= start_all_d;
    end
  end

  // The offset counter always equals the offset of the symbol that produced
  // the current active vector, so it doubles as report_offset.
  assign cfg_err       = cfg_err_q;
  assign active_state  = active_q;
  assign report_vec    = active_q & REPORT_MASK;
  assign report_any    = |report_vec;
  assign report_offset = ctr_q;

endmodule

// File: tb/tb_nfa_engine_prog.sv
// Scoreboard bench for nfa_engine_prog: stimulus tasks push hand-computed
// expected results, a monitor pops and compares them when a step completes.
module tb_nfa_engine_prog;

  localparam int N  = 16;
  localparam int SW = 8;
  localparam int OW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run = 1'b0;
  logic          stream_start = 1'b0;
  logic [SW-1:0] symbols = '0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_sel = '0;
  logic [SW-1:0] cfg_addr = '0;
  logic [N-1:0]  cfg_data = '0;
  logic          cfg_err;
  logic [N-1:0]  active_state;
  logic [N-1:0]  report_vec;
  logic          report_any;
  logic [OW-1:0] report_offset;

  nfa_engine_prog #(.NUM_STES(N), .SYMBOL_W(SW), .OFFSET_W(OW)) dut (
    .clk(clk), .reset(reset), .run(run), .stream_start(stream_start),
    .symbols(symbols), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .active_state(active_state),
    .report_vec(report_vec), .report_any(report_any), .report_offset(report_offset)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  act;
    logic [OW-1:0] off;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected error pulse: a write is rejected if the engine is running or a
  // predecessor row targets a non-existent STE.
  logic exp_err;
  logic stepped;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_err <= 1'b0;
      stepped <= 1'b0;
    end else begin
      exp_err <= cfg_we && (run || (cfg_sel == 2'd1 && cfg_addr >= SW'(N)));
      stepped <= run;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares completed steps against the scoreboard, checks that
  // idle cycles hold the last result, and checks cfg_err every cycle.
  exp_t last_exp = '{act: '0, off: '0};
  always @(negedge clk) begin
    if (!reset) begin
      last_exp = '{act: '0, off: '0};
    end else begin
      check("cfg_err", 32'(cfg_err), 32'(exp_err));
      if (stepped) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", 32'(1), 32'(0));
        end else begin
          last_exp = exp_q.pop_front();
          check("active_state", 32'(active_state), 32'(last_exp.act));
          check("report_vec", 32'(report_vec), 32'(last_exp.act));
          check("report_any", 32'(report_any), 32'(|last_exp.act));
          check("report_offset", 32'(report_offset), 32'(last_exp.off));
        end
      end else begin
        check("hold_active", 32'(active_state), 32'(last_exp.act));
        check("hold_offset", 32'(report_offset), 32'(last_exp.off));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [SW-1:0] addr, input logic [N-1:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_addr = addr; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic step(input logic [SW-1:0] sym, input logic ss, input logic [N-1:0] act, input logic [OW-1:0] off);
    exp_t e;
    e.act = act;
    e.off = off;
    exp_q.push_back(e);
    run = 1'b1; stream_start = ss; symbols = sym;
    tick();
    run = 1'b0; stream_start = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic idle(input int n, input logic ss);
    stream_start = ss;
    repeat (n) tick();
    stream_start = 1'b0;
  endtask

  initial begin
    #12;
    check("rst_active", 32'(active_state), 32'(0));
    check("rst_offset", 32'(report_offset), 32'(0));
    check("rst_any", 32'(report_any), 32'(0));
    check("rst_cfg_err", 32'(cfg_err), 32'(0));
    @(negedge clk); reset = 1'b1;
    tick();

    // Two-state chain 0x41 -> 0x42
    cfg_write(2'd0, 8'h41, 16'h0001);
    cfg_write(2'd0, 8'h42, 16'h0002);
    cfg_write(2'd1, 8'd1,  16'h0001);
    cfg_write(2'd2, 8'd0,  16'h0001);
    step(8'h41, 1'b0, 16'h0001, 16'd0);
    step(8'h42, 1'b0, 16'h0002, 16'd1);

    // New stream: 0x42 has no start STE; then the chain again from offset 0
    step(8'h42, 1'b1, 16'h0000, 16'd0);
    step(8'h41, 1'b1, 16'h0001, 16'd0);
    step(8'h42, 1'b0, 16'h0002, 16'd1);

    // Stall with stream_start asserted while idle: must hold and not latch
    step(8'h41, 1'b1, 16'h0001, 16'd0);
    idle(3, 1'b1);
    step(8'h42, 1'b0, 16'h0002, 16'd1);

    // Write attempted during a step: rejected, step proceeds, table intact
    cfg_we = 1'b1; cfg_sel = 2'd0; cfg_addr = 8'h41; cfg_data = 16'h0000;
    step(8'h41, 1'b1, 16'h0001, 16'd0);
    step(8'h42, 1'b0, 16'h0002, 16'd1);
    tick();
    step(8'h41, 1'b1, 16'h0001, 16'd0);

    // Out-of-range predecessor row: rejected, row 0 must not be touched
    cfg_write(2'd1, 8'd16, 16'hFFFF);
    tick();
    step(8'h41, 1'b1, 16'h0001, 16'd0);
    step(8'h41, 1'b0, 16'h0000, 16'd1);

    // All-input start on STE2 with self-loop over symbols 0x00-0x0F
    cfg_write(2'd3, 8'd0, 16'h0004);
    cfg_write(2'd1, 8'd2, 16'h0004);
    for (int s = 0; s < 16; s++) cfg_write(2'd0, SW'(s), 16'h0004);
    step(8'h05, 1'b1, 16'h0004, 16'd0);
    step(8'h30, 1'b0, 16'h0000, 16'd1);
    step(8'h07, 1'b0, 16'h0004, 16'd2);
    step(8'h08, 1'b0, 16'h0004, 16'd3);

    // Async reset between edges mid-stream
    step(8'h41, 1'b1, 16'h0001, 16'd0);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    check("async_active", 32'(active_state), 32'(0));
    check("async_any", 32'(report_any), 32'(0));
    check("async_offset", 32'(report_offset), 32'(0));
    @(negedge clk); #1;
    reset = 1'b1;
    tick();
    step(8'h41, 1'b0, 16'h0000, 16'd0);
    step(8'h05, 1'b0, 16'h0000, 16'd1);

    // Drain scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
